cache_tag_nway: RTL and testbench
=================================

CACHE_TAG_NWAY -- requirements
Module: cache_tag_nway

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_WIDTH, default 9, set-index width; the block has 2**ADDR_WIDTH sets.
- TAG_WIDTH, default 21, tag width.
- WAYS, default 4, associativity; legal values 2, 4, 8.
- WAY_W, default $clog2(WAYS), way-number width.

REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- lk_req  in  1  lookup request.
- lk_index  in  ADDR_WIDTH  lookup set.
- lk_tag  in  TAG_WIDTH  lookup tag.
- rsp_valid  out  1  lookup result valid.
- rsp_hit  out  1  hit.
- rsp_way  out  WAY_W  hit way.
- rsp_dirty  out  1  dirty bit of the hit way.
- vic_way  out  WAY_W  victim way.
- vic_valid  out  1  victim valid.
- vic_dirty  out  1  victim dirty.
- vic_tag  out  TAG_WIDTH  victim tag.
- upd_en  in  1  entry write.
- upd_index  in  ADDR_WIDTH  write set.
- upd_way  in  WAY_W  write way.
- upd_tag  in  TAG_WIDTH  written tag.
- upd_valid  in  1  written valid bit.
- upd_dirty  in  1  written dirty bit.
- upd_alloc  in  1  the write is an allocation; advances the replacement pointer.
- inv_req  in  1  invalidate-all request.
- busy  out  1  init or invalidate sweep in progress.

Function
REQ-003 Each set SHALL hold, per way, {valid, dirty, tag[TAG_WIDTH-1:0]}, plus one WAY_W-bit round-robin pointer per set.
REQ-004 Lookup SHALL have 1-cycle latency: lk_req sampled at edge N with busy=0 gives rsp_valid=1 for exactly the cycle after edge N; otherwise rsp_valid=0.
REQ-005 A way SHALL match when valid=1 and its stored tag equals lk_tag; rsp_hit = OR of all way matches.
REQ-006 On a hit, rsp_way SHALL be the lowest-numbered matching way; multiple matches are a caller contract violation and still resolve to the lowest way.
REQ-007 rsp_dirty SHALL equal the dirty bit of rsp_way; when rsp_hit=0, rsp_way=0 and rsp_dirty=0.
REQ-008 Victim selection SHALL pick the lowest-numbered invalid way if any exists (vic_valid=0); otherwise the way at the set's pointer (vic_valid=1).
REQ-009 vic_tag and vic_dirty SHALL be the stored tag and dirty bit of vic_way; vic_* are valid with rsp_valid regardless of hit.
REQ-010 upd_en sampled at edge N SHALL write {upd_valid, upd_dirty, upd_tag} to (upd_index, upd_way) at edge N; other ways of that set are unchanged.
REQ-011 If upd_alloc=1 together with upd_en, the set pointer SHALL become upd_way+1 modulo WAYS; upd_alloc with upd_en=0 SHALL be ignored.
REQ-012 Same-edge write and lookup to the same index SHALL be write-first: the response reflects the newly written entry and the updated pointer.
REQ-013 upd_en while busy=1 SHALL be ignored; lk_req while busy=1 SHALL be dropped, with no response.
REQ-014 The FSM SHALL have three states:
- INIT: sweep; entered on reset.
- IDLE.
- INV: sweep; entered from IDLE when inv_req=1 is sampled.
REQ-015 A sweep SHALL clear valid, dirty and pointer for one set per cycle, from set 0 to set 2**ADDR_WIDTH-1, then go to IDLE; the sweep takes exactly 2**ADDR_WIDTH cycles.
REQ-016 busy SHALL be 1 in INIT and INV and 0 in IDLE.
REQ-017 inv_req while busy=1 SHALL be ignored.
REQ-018 inv_req, lk_req and upd_en on the same edge in IDLE: the update and lookup are serviced (lookup responds next cycle), then the sweep starts.
REQ-019 The set-index counter SHALL wrap from its maximum to 0 only on sweep exit.
REQ-020 Tag storage SHALL be inferable as synchronous-read RAM.
REQ-021 valid, dirty and pointer bits SHALL be held in flops or RAM such that the sweep and the REQ-012 forwarding both hold.

Reset
REQ-022 rst_n=0 sampled at an edge SHALL force these values at that edge:
- FSM = INIT, sweep index = 0, busy = 1.
- rsp_valid = 0, rsp_hit = 0, rsp_way = 0, rsp_dirty = 0.
- vic_way = 0, vic_valid = 0, vic_dirty = 0, vic_tag = 0.
REQ-023 Reset asserted mid-sweep or mid-lookup SHALL abort the operation and restart INIT from set 0.
REQ-024 Stored entries SHALL be guaranteed invalid only after INIT completes.

Verification
All scenarios use ADDR_WIDTH=4, TAG_WIDTH=8, WAYS=4.
REQ-025 Reset, then lookup: release rst_n -> busy=1 for exactly 16 cycles; then lk_req index 3, tag 0x5A -> rsp_valid=1, rsp_hit=0, vic_way=0, vic_valid=0.
REQ-026 Hit: upd index 3, way 2, tag 0x5A, valid 1, dirty 1 -> lookup index 3, tag 0x5A gives rsp_hit=1, rsp_way=2, rsp_dirty=1.
REQ-027 Round-robin replacement: fill ways 0-3 of set 5 with upd_alloc=1 -> next lookup gives vic_valid=1, vic_way=0; after allocating way 0 again -> vic_way=1.
REQ-028 Write-first: same-edge upd (index 7, way 1, tag 0x33, valid 1) and lk (index 7, tag 0x33) -> next cycle rsp_hit=1, rsp_way=1.
REQ-029 Invalidate: inv_req in IDLE -> busy=1 for 16 cycles, a lk_req issued at busy cycle 4 gets no rsp_valid; after the sweep, lookup of tag 0x5A at index 3 misses and vic_dirty=0.
REQ-030 Reset mid-sweep: rst_n=0 at INV cycle 8 -> after release, busy=1 for a full 16 cycles.

Source files
------------

// File: rtl/cache_tag_nway.sv
// N-way set-associative tag directory: 1-cycle lookup with hit/victim selection, round-robin replacement.
// Lookup latency 1 cycle; lookups and updates are dropped while an init/invalidate sweep holds busy high.
module cache_tag_nway #(
    parameter int ADDR_WIDTH = 9,
    parameter int TAG_WIDTH  = 21,
    parameter int WAYS       = 4,
    parameter int WAY_W      = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lk_req,
    input  logic [ADDR_WIDTH-1:0] lk_index,
    input  logic [TAG_WIDTH-1:0]  lk_tag,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [WAY_W-1:0]      rsp_way,
    output logic                  rsp_dirty,
    output logic [WAY_W-1:0]      vic_way,
    output logic                  vic_valid,
    output logic                  vic_dirty,
    output logic [TAG_WIDTH-1:0]  vic_tag,
    input  logic                  upd_en,
    input  logic [ADDR_WIDTH-1:0] upd_index,
    input  logic [WAY_W-1:0]      upd_way,
    input  logic [TAG_WIDTH-1:0]  upd_tag,
    input  logic                  upd_valid,
    input  logic                  upd_dirty,
    input  logic                  upd_alloc,
    input  logic                  inv_req,
    output logic                  busy
);
    localparam int SETS = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_INV} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    rsp_vld_q;

    logic [WAYS-1:0]         vld_q [SETS];
    logic [WAYS-1:0]         dty_q [SETS];
    logic [WAY_W-1:0]        ptr_q [SETS];

    logic [TAG_WIDTH-1:0]    lk_tag_q;
    logic [WAYS-1:0]         set_vld_d, set_vld_q;
    logic [WAYS-1:0]         set_dty_d, set_dty_q;
    logic [WAY_W-1:0]        set_ptr_d, set_ptr_q;
    logic [TAG_WIDTH-1:0]    rd_tag [WAYS];

    logic                    wr_en;
    logic                    fwd;
    logic [WAY_W-1:0]        ptr_nxt;

    assign busy    = (state_q != S_IDLE);
    assign wr_en   = upd_en & ~busy;
    assign fwd     = wr_en && (upd_index == lk_index);
    assign ptr_nxt = upd_way + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            idx_q     <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            rsp_vld_q <= lk_req & ~busy;
            case (state_q)
                S_IDLE: begin
                    if (inv_req) begin
                        state_q <= S_INV;
                        idx_q   <= '0;
                    end
                end
                default: begin
                    if (&idx_q) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Sweep owns the flag arrays while busy; updates are only accepted in IDLE.
    always_ff @(posedge clk) begin
        if (busy) begin
            vld_q[idx_q] <= '0;
            dty_q[idx_q] <= '0;
            ptr_q[idx_q] <= '0;
        end else if (upd_en) begin
            vld_q[upd_index][upd_way] <= upd_valid;
            dty_q[upd_index][upd_way] <= upd_dirty;
            if (upd_alloc) begin
                ptr_q[upd_index] <= ptr_nxt;
            end
        end
    end

    always_comb begin
        set_vld_d = vld_q[lk_index];
        set_dty_d = dty_q[lk_index];
        set_ptr_d = ptr_q[lk_index];
        if (fwd) begin
            set_vld_d[upd_way] = upd_valid;
            set_dty_d[upd_way] = upd_dirty;
            if (upd_alloc) begin
                set_ptr_d = ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        lk_tag_q  <= lk_tag;
        set_vld_q <= set_vld_d;
        set_dty_q <= set_dty_d;
        set_ptr_q <= set_ptr_d;
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [TAG_WIDTH-1:0] mem [SETS];
        logic [TAG_WIDTH-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en && (upd_way == WAY_W'(g))) begin
                mem[upd_index] <= upd_tag;
            end
            rd_q <= (fwd && (upd_way == WAY_W'(g))) ? upd_tag : mem[lk_index];
        end

        assign rd_tag[g] = rd_q;
    end

    logic             hit_c;
    logic [WAY_W-1:0] way_c;
    logic             inv_found;
    logic [WAY_W-1:0] vway_c;

    // Descending scans so the lowest-numbered candidate wins.
    always_comb begin
        hit_c     = 1'b0;
        way_c     = '0;
        inv_found = 1'b0;
        vway_c    = set_ptr_q;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_vld_q[w] && (rd_tag[w] == lk_tag_q)) begin
                hit_c = 1'b1;
                way_c = WAY_W'(w);
            end
            if (!set_vld_q[w]) begin
                inv_found = 1'b1;
                vway_c    = WAY_W'(w);
            end
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_hit   = rsp_vld_q & hit_c;
    assign rsp_way   = rsp_vld_q ? way_c : '0;
    assign rsp_dirty = rsp_vld_q & hit_c & set_dty_q[way_c];
    assign vic_way   = rsp_vld_q ? vway_c : '0;
    assign vic_valid = rsp_vld_q & ~inv_found;
    assign vic_dirty = rsp_vld_q & set_dty_q[vway_c];
    assign vic_tag   = rsp_vld_q ? rd_tag[vway_c] : '0;

endmodule

// File: tb/tb_cache_tag_nway.sv
// Directed bench for cache_tag_nway with a reference model feeding a response scoreboard.
module tb_cache_tag_nway;
    localparam int AW = 4;
    localparam int TW = 8;
    localparam int NW = 4;
    localparam int WW = 2;
    localparam int NS = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lk_req;
    logic [AW-1:0] lk_index;
    logic [TW-1:0] lk_tag;
    logic          rsp_valid, rsp_hit, rsp_dirty;
    logic [WW-1:0] rsp_way, vic_way;
    logic          vic_valid, vic_dirty;
    logic [TW-1:0] vic_tag;
    logic          upd_en;
    logic [AW-1:0] upd_index;
    logic [WW-1:0] upd_way;
    logic [TW-1:0] upd_tag;
    logic          upd_valid, upd_dirty, upd_alloc;
    logic          inv_req;
    logic          busy;

    always #5 clk = ~clk;

    cache_tag_nway #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .WAYS(NW), .WAY_W(WW)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_dirty(rsp_dirty),
        .vic_way(vic_way), .vic_valid(vic_valid), .vic_dirty(vic_dirty), .vic_tag(vic_tag),
        .upd_en(upd_en), .upd_index(upd_index), .upd_way(upd_way), .upd_tag(upd_tag),
        .upd_valid(upd_valid), .upd_dirty(upd_dirty), .upd_alloc(upd_alloc),
        .inv_req(inv_req), .busy(busy)
    );

    typedef struct {
        bit          hit;
        bit [WW-1:0] way;
        bit          dirty;
        bit [WW-1:0] vway;
        bit          vvalid;
        bit          vdirty;
        bit [TW-1:0] vtag;
        bit          vtag_known;
    } exp_t;

    exp_t        sb[$];
    bit          m_vld   [NS][NW];
    bit          m_dty   [NS][NW];
    bit [TW-1:0] m_tag   [NS][NW];
    bit          m_known [NS][NW];
    bit [WW-1:0] m_ptr   [NS];
    int          sweep_left = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic exp_t predict(input int s, input bit [TW-1:0] t);
        exp_t e;
        bit   found;
        e = '{default: 0};
        found = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (!e.hit && m_vld[s][w] && m_tag[s][w] == t) begin
                e.hit   = 1'b1;
                e.way   = WW'(w);
                e.dirty = m_dty[s][w];
            end
            if (!found && !m_vld[s][w]) begin
                found  = 1'b1;
                e.vway = WW'(w);
            end
        end
        if (!found) e.vway = m_ptr[s];
        e.vvalid     = !found;
        e.vdirty     = m_dty[s][e.vway];
        e.vtag       = m_tag[s][e.vway];
        e.vtag_known = m_known[s][e.vway];
        return e;
    endfunction

    // Advance the model with the inputs about to be sampled, clock once, then check.
    task automatic tick();
        bit   pushed;
        exp_t e;
        pushed = 1'b0;
        if (!rst_n) begin
            sweep_left = NS;
        end else if (sweep_left > 0) begin
            for (int w = 0; w < NW; w++) begin
                m_vld[NS - sweep_left][w] = 1'b0;
                m_dty[NS - sweep_left][w] = 1'b0;
            end
            m_ptr[NS - sweep_left] = '0;
            sweep_left--;
        end else begin
            if (upd_en) begin
                m_vld[upd_index][upd_way]   = upd_valid;
                m_dty[upd_index][upd_way]   = upd_dirty;
                m_tag[upd_index][upd_way]   = upd_tag;
                m_known[upd_index][upd_way] = 1'b1;
                if (upd_alloc) m_ptr[upd_index] = WW'((int'(upd_way) + 1) % NW);
            end
            if (lk_req) begin
                sb.push_back(predict(int'(lk_index), lk_tag));
                pushed = 1'b1;
            end
            if (inv_req) sweep_left = NS;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(pushed));
        chk("busy", 32'(busy), 32'(sweep_left > 0));
        if (pushed) begin
            e = sb.pop_front();
            chk("sb_hit", 32'(rsp_hit), 32'(e.hit));
            chk("sb_way", 32'(rsp_way), 32'(e.way));
            chk("sb_dirty", 32'(rsp_dirty), 32'(e.dirty));
            chk("sb_vic_way", 32'(vic_way), 32'(e.vway));
            chk("sb_vic_valid", 32'(vic_valid), 32'(e.vvalid));
            chk("sb_vic_dirty", 32'(vic_dirty), 32'(e.vdirty));
            if (e.vtag_known) chk("sb_vic_tag", 32'(vic_tag), 32'(e.vtag));
        end
    endtask

    task automatic clr();
        lk_req = 0; lk_index = '0; lk_tag = '0;
        upd_en = 0; upd_index = '0; upd_way = '0; upd_tag = '0;
        upd_valid = 0; upd_dirty = 0; upd_alloc = 0; inv_req = 0;
    endtask

    task automatic lookup(input int s, input int t);
        lk_req = 1; lk_index = AW'(s); lk_tag = TW'(t);
        tick();
        clr();
    endtask

    task automatic set_upd(input int s, input int w, input int t, input bit v, input bit d, input bit a);
        upd_en = 1; upd_index = AW'(s); upd_way = WW'(w); upd_tag = TW'(t);
        upd_valid = v; upd_dirty = d; upd_alloc = a;
    endtask

    int n;

    initial begin
        rst_n = 0;
        clr();
        repeat (3) tick();
        chk("rst_hit", 32'(rsp_hit), 0);
        chk("rst_way", 32'(rsp_way), 0);
        chk("rst_dirty", 32'(rsp_dirty), 0);
        chk("rst_vic_way", 32'(vic_way), 0);
        chk("rst_vic_valid", 32'(vic_valid), 0);
        chk("rst_vic_dirty", 32'(vic_dirty), 0);
        chk("rst_vic_tag", 32'(vic_tag), 0);

        rst_n = 1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick(); n++; end
        chk("init_len", 32'(n), 16);

        lookup(3, 'h5A);
        chk("s1_hit", 32'(rsp_hit), 0);
        chk("s1_vic_way", 32'(vic_way), 0);
        chk("s1_vic_valid", 32'(vic_valid), 0);

        set_upd(3, 2, 'h5A, 1, 1, 0); tick(); clr();
        lookup(3, 'h5A);
        chk("hit_hit", 32'(rsp_hit), 1);
        chk("hit_way", 32'(rsp_way), 2);
        chk("hit_dirty", 32'(rsp_dirty), 1);

        for (int w = 0; w < NW; w++) begin
            set_upd(5, w, 'h10 + w, 1, 0, 1); tick(); clr();
        end
        lookup(5, 'h99);
        chk("rr_vic_valid", 32'(vic_valid), 1);
        chk("rr_vic_way0", 32'(vic_way), 0);
        chk("rr_vic_tag", 32'(vic_tag), 'h10);
        set_upd(5, 0, 'h20, 1, 0, 1); tick(); clr();
        lookup(5, 'h99);
        chk("rr_vic_way1", 32'(vic_way), 1);

        set_upd(7, 1, 'h33, 1, 0, 0);
        lookup(7, 'h33);
        chk("wf_hit", 32'(rsp_hit), 1);
        chk("wf_way", 32'(rsp_way), 1);

        set_upd(5, 1, 'h21, 1, 0, 1);
        lookup(5, 'h21);
        chk("wf_ptr_way", 32'(rsp_way), 1);
        chk("wf_ptr_vic", 32'(vic_way), 2);

        upd_alloc = 1; upd_index = 5; upd_way = 3;
        lookup(5, 'h99);
        chk("alloc_no_en", 32'(vic_way), 2);

        set_upd(9, 3, 'h44, 1, 1, 0); tick(); clr();
        set_upd(9, 1, 'h44, 1, 0, 0); tick(); clr();
        lookup(9, 'h44);
        chk("multi_way", 32'(rsp_way), 1);
        chk("multi_dirty", 32'(rsp_dirty), 0);

        for (int i = 0; i < 4; i++) begin
            lk_req = 1; lk_index = AW'(3 + 2 * i); lk_tag = 8'h5A;
            tick();
        end
        clr();

        set_upd(2, 0, 'h66, 1, 0, 0);
        inv_req = 1;
        lookup(2, 'h66);
        chk("inv_same_hit", 32'(rsp_hit), 1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 3) begin lk_req = 1; lk_index = 3; lk_tag = 8'h5A; end
            if (n == 5) inv_req = 1;
            if (n == 9) set_upd(0, 0, 'h77, 1, 1, 0);
            tick();
            clr();
            n++;
        end
        chk("inv_len", 32'(n), 16);
        lookup(3, 'h5A);
        chk("inv_miss", 32'(rsp_hit), 0);
        chk("inv_vic_dirty", 32'(vic_dirty), 0);
        lookup(0, 'h77);
        chk("busy_upd_drop", 32'(rsp_hit), 0);

        inv_req = 1; tick(); clr();
        repeat (7) tick();
        rst_n = 0; tick();
        rst_n = 1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick(); n++; end
        chk("rst_mid_len", 32'(n), 16);
        lookup(7, 'h33);
        chk("rst_mid_miss", 32'(rsp_hit), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
